// File: rtl/svc_rv_mem_model.sv
// svc_rv_mem_model: shared instruction/data word memory with configurable read latency.
//   clock/reset       : rising-edge clock, async active-high reset (read pipelines only)
//   imem_ren/raddr    : instruction read request -> imem_rdata/imem_rvalid after IMEM_LAT cycles
//   dmem_ren/raddr    : data read request -> dmem_rdata/dmem_rvalid after DMEM_LAT cycles
//   dmem_we/waddr/... : byte-strobed data write
//   load_we/addr/data : full-word preload write, wins over a same-cycle data write
//   Define SVC_RV_MEM_WRITE_FWD_EN to forward same-cycle writes into reads.
module svc_rv_mem_model #(
    parameter int          WORDS         = 1024,
    parameter int          IMEM_LAT      = 0,
    parameter int          DMEM_LAT      = 0,
    parameter logic [31:0] IMEM_RST_DATA = 32'h00000013,
    parameter logic [31:0] DMEM_RST_DATA = 32'h00000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_ren,
    input  logic [31:0] imem_raddr,
    output logic [31:0] imem_rdata,
    output logic        imem_rvalid,
    input  logic        dmem_ren,
    input  logic [31:0] dmem_raddr,
    output logic [31:0] dmem_rdata,
    output logic        dmem_rvalid,
    input  logic        dmem_we,
    input  logic [31:0] dmem_waddr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int AW = $clog2(WORDS);

    logic [31:0]   mem_q [WORDS];
    logic [AW-1:0] i_idx, d_idx, w_idx, l_idx, wr_idx;
    logic          wr_en;
    logic [31:0]   wr_word, i_word, d_word;
    logic          unused_bits;

    assign i_idx = imem_raddr[AW+1:2];
    assign d_idx = dmem_raddr[AW+1:2];
    assign w_idx = dmem_waddr[AW+1:2];
    assign l_idx = load_addr[AW+1:2];

    // Byte offsets and bits above the array wrap are ignored by design.
    assign unused_bits = ^{imem_raddr[31:AW+2], imem_raddr[1:0], dmem_raddr[31:AW+2],
                           dmem_raddr[1:0], dmem_waddr[31:AW+2], dmem_waddr[1:0],
                           load_addr[31:AW+2], load_addr[1:0], IMEM_RST_DATA, DMEM_RST_DATA};

    // The single effective write of this cycle: a preload drops any data write,
    // and a data write with no strobes is not a write at all.
    always_comb begin
        wr_en   = ~reset & (load_we | (dmem_we & |dmem_wstrb));
        wr_idx  = load_we ? l_idx : w_idx;
        wr_word = load_data;
        if (!load_we)
            for (int i = 0; i < 4; i++)
                wr_word[8*i+:8] = dmem_wstrb[i] ? dmem_wdata[8*i+:8] : mem_q[w_idx][8*i+:8];
    end

    always_ff @(posedge clock)
        if (wr_en) mem_q[wr_idx] <= wr_word;

`ifdef SVC_RV_MEM_WRITE_FWD_EN
    assign i_word = (wr_en && wr_idx == i_idx) ? wr_word : mem_q[i_idx];
    assign d_word = (wr_en && wr_idx == d_idx) ? wr_word : mem_q[d_idx];
`else
    assign i_word = mem_q[i_idx];
    assign d_word = mem_q[d_idx];
`endif

    generate
        if (IMEM_LAT == 0) begin : g_imem_comb
            assign imem_rdata  = imem_ren ? i_word : '0;
            assign imem_rvalid = imem_ren;
        end else begin : g_imem_pipe
            logic [31:0]         stg_q [IMEM_LAT];
            logic [31:0]         stg_d [IMEM_LAT];
            logic [IMEM_LAT-1:0] vld_q, vld_d;
            // Stage 1 holds its word when idle, like a BRAM output register.
            always_comb begin
                stg_d[0] = imem_ren ? i_word : stg_q[0];
                vld_d[0] = imem_ren;
                for (int k = 1; k < IMEM_LAT; k++) begin
                    stg_d[k] = stg_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end
            always_ff @(posedge clock or posedge reset)
                if (reset) begin
                    for (int k = 0; k < IMEM_LAT; k++) stg_q[k] <= IMEM_RST_DATA;
                    vld_q <= '0;
                end else begin
                    stg_q <= stg_d;
                    vld_q <= vld_d;
                end
            assign imem_rdata  = stg_q[IMEM_LAT-1];
            assign imem_rvalid = vld_q[IMEM_LAT-1];
        end

        if (DMEM_LAT == 0) begin : g_dmem_comb
            assign dmem_rdata  = dmem_ren ? d_word : '0;
            assign dmem_rvalid = dmem_ren;
        end else begin : g_dmem_pipe
            logic [31:0]         stg_q [DMEM_LAT];
            logic [31:0]         stg_d [DMEM_LAT];
            logic [DMEM_LAT-1:0] vld_q, vld_d;
            always_comb begin
                stg_d[0] = dmem_ren ? d_word : stg_q[0];
                vld_d[0] = dmem_ren;
                for (int k = 1; k < DMEM_LAT; k++) begin
                    stg_d[k] = stg_q[k-1];
                    vld_d[k] = vld_q[k-1];
                end
            end
            always_ff @(posedge clock or posedge reset)
                if (reset) begin
                    for (int k = 0; k < DMEM_LAT; k++) stg_q[k] <= DMEM_RST_DATA;
                    vld_q <= '0;
                end else begin
                    stg_q <= stg_d;
                    vld_q <= vld_d;
                end
            assign dmem_rdata  = stg_q[DMEM_LAT-1];
            assign dmem_rvalid = vld_q[DMEM_LAT-1];
        end
    endgenerate
endmodule

// File: tb/tb_svc_rv_mem_model.sv
// tb_svc_rv_mem_model: bench for svc_rv_mem_model (pipelined and combinational instances).
module tb_svc_rv_mem_model;
    localparam int N = 1024;
    localparam int WORDS = 32;
`ifdef SVC_RV_MEM_WRITE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clock, reset, imem_ren, dmem_ren, dmem_we, load_we;
    logic [31:0] imem_raddr, dmem_raddr, dmem_waddr, dmem_wdata, load_addr, load_data;
    logic [3:0]  dmem_wstrb;
    logic [31:0] a_irdata, a_drdata, b_irdata, b_drdata;
    logic        a_irvalid, a_drvalid, b_irvalid, b_drvalid;

    int checks = 0, errors = 0, cyc = 0;

    // Reference memory plus per-cycle history of requests and the words they saw.
    logic [31:0] mdl [WORDS];
    bit          rst_h [N];
    bit          ren_h [2][N];
    logic [31:0] word_h [2][N];

    bit          p_ren [8] = '{1, 1, 0, 1, 0, 0, 0, 0};
    logic [31:0] p_addr [8] = '{32'h0, 32'h4, 32'h0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0};
    bit          p_v [8] = '{0, 0, 0, 1, 1, 0, 1, 0};
    logic [31:0] p_d [8] = '{32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 32'h11213141,
                             32'h11213141, 32'hAAAAAAAA, 32'hAAAAAAAA};

    svc_rv_mem_model #(.WORDS(WORDS), .IMEM_LAT(1), .DMEM_LAT(3)) u_a (
        .clock(clock), .reset(reset),
        .imem_ren(imem_ren), .imem_raddr(imem_raddr), .imem_rdata(a_irdata), .imem_rvalid(a_irvalid),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(a_drdata), .dmem_rvalid(a_drvalid),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    svc_rv_mem_model #(.WORDS(WORDS), .IMEM_LAT(0), .DMEM_LAT(0)) u_b (
        .clock(clock), .reset(reset),
        .imem_ren(imem_ren), .imem_raddr(imem_raddr), .imem_rdata(b_irdata), .imem_rvalid(b_irvalid),
        .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(b_drdata), .dmem_rvalid(b_drvalid),
        .dmem_we(dmem_we), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data));

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [4:0] ix(logic [31:0] a);
        return a[6:2];
    endfunction

    function automatic logic [31:0] merged(logic [31:0] old);
        logic [31:0] w = old;
        for (int i = 0; i < 4; i++)
            if (dmem_wstrb[i]) w[8*i+:8] = dmem_wdata[8*i+:8];
        return w;
    endfunction

    // Word a read of address a sees this cycle (old contents unless forwarding is built in).
    function automatic logic [31:0] mdl_rd(logic [31:0] a);
        logic [31:0] w = mdl[ix(a)];
        if (FWD && !reset) begin
            if (load_we) begin
                if (ix(load_addr) == ix(a)) w = load_data;
            end else if (dmem_we && ix(dmem_waddr) == ix(a)) w = merged(w);
        end
        return w;
    endfunction

    function automatic int last_rst(int c);
        for (int k = c; k > 0; k--)
            if (rst_h[k]) return k;
        return 0;
    endfunction

    // Latency-L output: reset value if reset touched the last L cycles, else the
    // word of the newest request at least L cycles old since the last reset.
    function automatic logic [31:0] exp_rdata(int p, int c, int l, logic [31:0] rd);
        int r = last_rst(c);
        if (r > c - l) return rd;
        for (int t = c - l; t > r; t--)
            if (ren_h[p][t]) return word_h[p][t];
        return rd;
    endfunction

    function automatic logic exp_rvalid(int p, int c, int l);
        int r = last_rst(c);
        return (r < c - l) && ren_h[p][c-l];
    endfunction

    always @(negedge clock) begin
        int c;
        c = cyc;
        if (c < N) begin
            rst_h[c] = reset;
            ren_h[0][c] = imem_ren;
            ren_h[1][c] = dmem_ren;
            word_h[0][c] = mdl_rd(imem_raddr);
            word_h[1][c] = mdl_rd(dmem_raddr);
            chk("b_irdata", b_irdata, imem_ren ? word_h[0][c] : 32'h0);
            chk("b_irvalid", b_irvalid, imem_ren);
            chk("b_drdata", b_drdata, dmem_ren ? word_h[1][c] : 32'h0);
            chk("b_drvalid", b_drvalid, dmem_ren);
            chk("a_irdata", a_irdata, exp_rdata(0, c, 1, 32'h00000013));
            chk("a_irvalid", a_irvalid, exp_rvalid(0, c, 1));
            chk("a_drdata", a_drdata, exp_rdata(1, c, 3, 32'h00000000));
            chk("a_drvalid", a_drvalid, exp_rvalid(1, c, 3));
            if (!reset) begin
                if (load_we) mdl[ix(load_addr)] = load_data;
                else if (dmem_we) mdl[ix(dmem_waddr)] = merged(mdl[ix(dmem_waddr)]);
            end
        end
    end

    task automatic nxt();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        imem_ren = 0; dmem_ren = 0; dmem_we = 0; load_we = 0; dmem_wstrb = 0;
    endtask

    initial begin
        reset = 0; imem_raddr = 0; dmem_raddr = 0; dmem_waddr = 0; dmem_wdata = 0;
        load_addr = 0; load_data = 0;
        idle();
        rst_h[0] = 1;
        #1 reset = 1;
        #1;
        chk("rst_irdata", a_irdata, 32'h00000013);
        chk("rst_irvalid", a_irvalid, 0);
        chk("rst_drvalid", a_drvalid, 0);
        chk("rst_drdata", a_drdata, 32'h0);
        repeat (2) nxt();
        reset = 0;
        for (int k = 0; k < WORDS; k++) begin
            load_we = 1; load_addr = 32'(k) * 4; load_data = 32'(k) * 32'h01010101 + 32'h10203040;
            nxt();
        end
        load_addr = 32'h10; load_data = 32'h1; nxt();
        load_addr = 32'h14; load_data = 32'hDEADBEEF; nxt();
        idle();
        // byte-strobed merge
        dmem_we = 1; dmem_waddr = 32'h14; dmem_wdata = 32'h11223344; dmem_wstrb = 4'b0101;
        nxt(); idle();
        dmem_ren = 1; dmem_raddr = 32'h14;
        #1 chk("strb_merge", b_drdata, 32'hDE22BE44);
        nxt(); idle();
        // address wrap
        imem_ren = 1; imem_raddr = 32'h84;
        #1 chk("wrap_rd", b_irdata, 32'h11213141);
        dmem_we = 1; dmem_waddr = 32'h83; dmem_wdata = 32'hCAFEF00D; dmem_wstrb = 4'hF;
        nxt(); idle();
        imem_ren = 1; imem_raddr = 32'h0;
        #1 chk("wrap_wr", b_irdata, 32'hCAFEF00D);
        nxt(); idle();
        // preload beats a same-cycle data write
        load_we = 1; load_addr = 32'h8; load_data = 32'hAAAAAAAA;
        dmem_we = 1; dmem_waddr = 32'hC; dmem_wdata = 32'h5; dmem_wstrb = 4'hF;
        nxt(); idle();
        imem_ren = 1; imem_raddr = 32'h8; dmem_ren = 1; dmem_raddr = 32'hC;
        #1 chk("prio_load", b_irdata, 32'hAAAAAAAA);
        chk("prio_drop", b_drdata, 32'h13233343);
        nxt(); idle();
        repeat (3) nxt();
        // DMEM_LAT=3 pipelined requests with a gap
        for (int j = 0; j < 8; j++) begin
            dmem_ren = p_ren[j]; dmem_raddr = p_addr[j];
            #1 chk("pipe_v", a_drvalid, p_v[j]);
            if (j >= 3) chk("pipe_d", a_drdata, p_d[j]);
            nxt();
        end
        idle();
        // read during write, then async reset on the response cycle
        imem_ren = 1; imem_raddr = 32'h10;
        dmem_we = 1; dmem_waddr = 32'h10; dmem_wdata = 32'h2; dmem_wstrb = 4'hF;
        #1 chk("rdw_lat0", b_irdata, FWD ? 32'h2 : 32'h1);
        nxt(); idle();
        #1 chk("rdw_lat1", a_irdata, FWD ? 32'h2 : 32'h1);
        chk("rdw_valid", a_irvalid, 1);
        reset = 1;
        #1 chk("arst_valid", a_irvalid, 0);
        chk("arst_data", a_irdata, 32'h00000013);
        nxt();
        reset = 0;
        // mixed traffic including mid-flight resets
        for (int n = 0; n < 150; n++) begin
            imem_ren = 1'($urandom_range(0, 1)); imem_raddr = $urandom_range(0, 255);
            dmem_ren = 1'($urandom_range(0, 1)); dmem_raddr = $urandom_range(0, 255);
            dmem_we = ($urandom_range(0, 2) == 0); dmem_waddr = $urandom_range(0, 255);
            dmem_wdata = $urandom; dmem_wstrb = 4'($urandom_range(0, 15));
            load_we = ($urandom_range(0, 7) == 0); load_addr = $urandom_range(0, 255);
            load_data = $urandom;
            reset = (n == 70 || n == 71 || n == 100);
            nxt();
        end
        reset = 0;
        idle();
        repeat (5) nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/svc_rv_mem_model.md
Name: svc_rv_mem_model

Overview:
- Parametrised instruction/data memory model for svc_rv cores in simulation and formal harnesses.
- One shared word array; an instruction read port, a data read port and a byte-strobed data write port.
- Read latency per port is configurable from 0 (SRAM-like) up to N cycles (BRAM plus extra register stages).
- Adds read-valid outputs and a preload port.

Parameters:
- WORDS, 1024, array depth in 32-bit words; power of two, >= 2.
- IMEM_LAT, 0, instruction read latency in cycles, 0..4.
- DMEM_LAT, 0, data read latency in cycles, 0..4.
- IMEM_RST_DATA, 32'h00000013, reset value of every instruction read stage (NOP).
- DMEM_RST_DATA, 32'h00000000, reset value of every data read stage.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all read pipeline stages, never the array.
- imem_ren  in  1  instruction read request.
- imem_raddr  in  32  instruction byte address.
- imem_rdata  out  32  instruction read data.
- imem_rvalid  out  1  imem_rdata carries the response to a request made IMEM_LAT cycles ago.
- dmem_ren  in  1  data read request.
- dmem_raddr  in  32  data byte address.
- dmem_rdata  out  32  data read data.
- dmem_rvalid  out  1  data response valid, DMEM_LAT cycles after dmem_ren.
- dmem_we  in  1  data write enable.
- dmem_waddr  in  32  data write byte address.
- dmem_wdata  in  32  write data.
- dmem_wstrb  in  4  byte-lane enables; bit i covers bits [8i+7:8i].
- load_we  in  1  preload write, full word.
- load_addr  in  32  preload byte address.
- load_data  in  32  preload data.

Behaviour:
- Indexing: AW = clog2(WORDS); word index = addr[AW+1:2]. addr[1:0] and bits above AW+1 are ignored, so addresses wrap modulo WORDS*4.
- Writes are applied at the clock edge.
  - dmem_we updates only the lanes whose dmem_wstrb bit is set.
  - dmem_wstrb = 0 is a no-op.
  - If load_we is set in the same cycle, load_we takes priority and the dmem write is dropped entirely, even at a different address.
  - Both writes are ignored while reset is asserted.
- Array contents are not reset. They are undefined until written; in formal they are free.
- LAT = 0 (either port):
  - rdata = array[idx] combinationally when ren = 1, and 0 otherwise.
  - rvalid = ren.
  - A same-cycle write is not visible to the read: it returns the old word.
- LAT = L >= 1:
  - Stage 1 loads array[idx] at the edge when ren = 1 and holds its value when ren = 0. This matches BRAM output-register hold.
  - Stages 2..L shift every cycle.
  - rdata = stage L.
  - A valid shift register of L bits tracks ren; rvalid = its last bit.
  - A same-cycle write to the read word is not visible: stage 1 captures the pre-write contents.
- Reset: asynchronously sets all imem stages to IMEM_RST_DATA, all dmem stages to DMEM_RST_DATA, and all valid bits to 0.
  - Reset outputs: imem_rvalid = 0, dmem_rvalid = 0, imem_rdata = IMEM_RST_DATA (LAT >= 1), dmem_rdata = DMEM_RST_DATA (LAT >= 1).
  - Reset mid-flight discards in-flight responses; no rvalid is produced for them.
- Back-to-back requests are fully pipelined: one request per port per cycle, responses in order, no stalls.
- The two read ports are independent. Both may address the same word in the same cycle.

Optional Feature:
- Macro: SVC_RV_MEM_WRITE_FWD_EN.
- Defined: a read (either port) whose word index matches a same-cycle dmem_we or load_we returns the merged word instead of the old word.
  - dmem write: wdata bytes on strobed lanes, old bytes elsewhere.
  - load write: load_data.
  - LAT = 0: the merge is combinational. LAT >= 1: stage 1 captures the merged word.
  - Priority rules for write collisions are unchanged.
- Undefined: read-during-write returns old contents, as described in Behaviour.

Test Plan:
- Reset with IMEM_LAT=1 -> imem_rdata=32'h00000013 and both rvalid=0 immediately, before any clock edge.
- Preload word 5 = 32'hDEADBEEF; dmem write addr 0x14, wdata 32'h11223344, wstrb 4'b0101; read addr 0x14 -> 32'hDE22BE44.
- DMEM_LAT=3: dmem_ren pulses at cycles 10, 11, 13 with addresses 0x0, 0x4, 0x8 -> dmem_rvalid at 13, 14, 16 with matching data in order.
- WORDS=32: read addr 0x84 -> returns word 1; write addr 0x83 -> modifies word 0.
- Same cycle: load_we to word 2 = 32'hAAAAAAAA and dmem_we to word 3 = 32'h5 -> word 2 = AAAAAAAA, word 3 unchanged.
- IMEM_LAT=1: read word 4 (old 32'h1) while dmem writes 32'h2 to it -> returns 1 without SVC_RV_MEM_WRITE_FWD_EN, 2 with it. Assert reset on the response cycle -> imem_rvalid drops to 0 immediately.
